// File: rtl/wish_pkg.sv
// Shared definitions for the Wishbone-stream packer/unpacker family:
// tag bit positions, unpacker state encoding and a clog2 helper.
package wish_pkg;

    localparam int TGC_FIRST = 0;
    localparam int TGC_LAST  = 1;

    typedef enum logic {
        UNP_EMPTY = 1'b0,
        UNP_EMIT  = 1'b1
    } unp_state_e;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wish_unpackn.sv
// Wishbone-stream unpacker: takes one beat of NUM_PACK words and emits them
// one word per transfer, first word chosen by LITTLE_ENDIAN.
// Build option: WISH_UNPACKN_CNT_EN enables partial beats via s_cnt_i.
module wish_unpackn
    import wish_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter int LITTLE_ENDIAN = 0,
    localparam int CNT_WIDTH    = clog2(NUM_PACK + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           s_cyc_i,
    input  logic                           s_stb_i,
    input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
    input  logic [TGC_WIDTH-1:0]           s_tgc_i,
    input  logic [CNT_WIDTH-1:0]           s_cnt_i,
    output logic                           s_stall_o,
    output logic                           s_ack_o,
    output logic                           d_cyc_o,
    output logic                           d_stb_o,
    output logic [DATA_WIDTH-1:0]          d_dat_o,
    output logic [TGC_WIDTH-1:0]           d_tgc_o,
    input  logic                           d_ack_i
);

    localparam int BEAT_W = DATA_WIDTH * NUM_PACK;

    unp_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [BEAT_W-1:0]     buf_q, buf_d;
    logic [TGC_WIDTH-1:0]  btgc_q, btgc_d;   // tags of the beat being emitted
    logic [TGC_WIDTH-1:0]  dtgc_q, dtgc_d;   // tags of the presented word
    logic                  in_pkt_q, in_pkt_d;
    logic                  cyc_q, cyc_d;
    logic                  ack_q, ack_d;

    logic                  xfer;
    logic                  last_word;
    logic                  stall;
    logic                  accept;
    logic [CNT_WIDTH-1:0]  cnt_eff;
    logic [BEAT_W-1:0]     buf_shift;

`ifdef WISH_UNPACKN_CNT_EN
    // Out-of-range counts fall back to a full beat.
    always_comb begin
        cnt_eff = s_cnt_i;
        if (s_cnt_i == '0 || s_cnt_i > CNT_WIDTH'(NUM_PACK))
            cnt_eff = CNT_WIDTH'(NUM_PACK);
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^s_cnt_i;
    assign cnt_eff    = CNT_WIDTH'(NUM_PACK);
`endif

    // The presented word always sits at the outgoing end of the buffer.
    if (LITTLE_ENDIAN != 0) begin : g_le
        assign buf_shift = buf_q >> DATA_WIDTH;
        assign d_dat_o   = buf_q[DATA_WIDTH-1:0];
    end else begin : g_be
        assign buf_shift = buf_q << DATA_WIDTH;
        assign d_dat_o   = buf_q[BEAT_W-1 -: DATA_WIDTH];
    end

    assign xfer      = (state_q == UNP_EMIT) && d_ack_i;
    assign last_word = (rem_q == CNT_WIDTH'(1));
    // A new beat may land in the same cycle the final word leaves.
    assign stall     = (state_q == UNP_EMIT) && !(xfer && last_word);
    assign accept    = s_cyc_i && s_stb_i && !stall;

    // Next-state, word shift and tag generation; a load overrides the shift.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        buf_d    = buf_q;
        btgc_d   = btgc_q;
        dtgc_d   = dtgc_q;
        in_pkt_d = in_pkt_q;
        ack_d    = accept;

        if (xfer) begin
            if (dtgc_q[TGC_LAST])
                in_pkt_d = 1'b0;
            else if (dtgc_q[TGC_FIRST])
                in_pkt_d = 1'b1;
            buf_d             = buf_shift;
            rem_d             = rem_q - CNT_WIDTH'(1);
            dtgc_d            = btgc_q;
            dtgc_d[TGC_FIRST] = 1'b0;
            dtgc_d[TGC_LAST]  = btgc_q[TGC_LAST] && (rem_q == CNT_WIDTH'(2));
            if (last_word)
                state_d = UNP_EMPTY;
        end

        if (accept) begin
            state_d          = UNP_EMIT;
            buf_d            = s_dat_i;
            rem_d            = cnt_eff;
            btgc_d           = s_tgc_i;
            dtgc_d           = s_tgc_i;
            dtgc_d[TGC_LAST] = s_tgc_i[TGC_LAST] && (cnt_eff == CNT_WIDTH'(1));
        end

        cyc_d = (state_d == UNP_EMIT) || in_pkt_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= UNP_EMPTY;
            rem_q    <= '0;
            buf_q    <= '0;
            btgc_q   <= '0;
            dtgc_q   <= '0;
            in_pkt_q <= 1'b0;
            cyc_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            buf_q    <= buf_d;
            btgc_q   <= btgc_d;
            dtgc_q   <= dtgc_d;
            in_pkt_q <= in_pkt_d;
            cyc_q    <= cyc_d;
            ack_q    <= ack_d;
        end
    end

    assign s_stall_o = stall;
    assign s_ack_o   = ack_q;
    assign d_stb_o   = (state_q == UNP_EMIT);
    assign d_cyc_o   = cyc_q;
    assign d_tgc_o   = dtgc_q;

endmodule

// File: tb/tb_wish_unpackn.sv
// Scoreboard bench for wish_unpackn: a big-endian and a little-endian
// instance share the source stimulus; a monitor checks every word transfer.
module tb_wish_unpackn;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_cyc, s_stb;
    logic [31:0] s_dat;
    logic [1:0]  s_tgc;
    logic [2:0]  s_cnt;
    logic        d_ack;

    logic       stall_be, ack_be, cyc_be, stb_be;
    logic [7:0] dat_be;
    logic [1:0] tgc_be;
    logic       stall_le, ack_le, cyc_le, stb_le;
    logic [7:0] dat_le;
    logic [1:0] tgc_le;

    typedef struct packed {
        logic [7:0] dat;
        logic [1:0] tgc;
    } exp_t;

    exp_t q_be[$];
    exp_t q_le[$];
    int   xfer_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    wish_unpackn #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(0)) u_be (
        .clk_i(clk), .rst_ni(rst_n), .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat),
        .s_tgc_i(s_tgc), .s_cnt_i(s_cnt), .s_stall_o(stall_be), .s_ack_o(ack_be),
        .d_cyc_o(cyc_be), .d_stb_o(stb_be), .d_dat_o(dat_be), .d_tgc_o(tgc_be), .d_ack_i(d_ack)
    );

    wish_unpackn #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1)) u_le (
        .clk_i(clk), .rst_ni(rst_n), .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat),
        .s_tgc_i(s_tgc), .s_cnt_i(s_cnt), .s_stall_o(stall_le), .s_ack_o(ack_le),
        .d_cyc_o(cyc_le), .d_stb_o(stb_le), .d_dat_o(dat_le), .d_tgc_o(tgc_le), .d_ack_i(d_ack)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Expected words of one beat carrying n valid words.
    task automatic push_beat(input logic [31:0] dat, input logic [1:0] tgc, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tgc = {tgc[1] && (i == n - 1), tgc[0] && (i == 0)};
            e.dat = dat[31 - 8*i -: 8];
            q_be.push_back(e);
            e.dat = dat[8*i +: 8];
            q_le.push_back(e);
        end
    endtask

    // Offer a beat until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] dat, input logic [1:0] tgc,
                        input logic [2:0] cnt, input int n);
        bit acc;
        int waitc;
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_dat = dat; s_tgc = tgc; s_cnt = cnt;
        push_beat(dat, tgc, n);
        acc = 1'b0;
        waitc = 0;
        while (!acc && waitc < 100) begin
            #4;
            acc = !stall_be;
            @(posedge clk);
            if (!acc) begin
                waitc++;
                @(negedge clk);
            end
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout got stalled exp accept dat %h", dat);
        end
        #1;
        chk("s_ack_be", ack_be, 1);
        chk("s_ack_le", ack_le, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        s_cyc = 1'b0; s_stb = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_be.size() != 0 || q_le.size() != 0 || stb_be || stb_le) && n < 60) begin
            @(negedge clk);
            #4;
            n++;
        end
        chk(name, q_be.size() + q_le.size() + {31'd0, stb_be} + {31'd0, stb_le}, 0);
    endtask

    // Monitor: pop and compare on every word transfer.
    always @(negedge clk) begin : mon
        exp_t e;
        #3;
        if (rst_n && d_ack) begin
            if (stb_be) begin
                xfer_log.push_back(cyc_n);
                if (q_be.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL be_extra got %h exp none", dat_be);
                end else begin
                    e = q_be.pop_front();
                    chk("be_word", {22'd0, dat_be, tgc_be}, {22'd0, e});
                end
            end
            if (stb_le) begin
                if (q_le.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL le_extra got %h exp none", dat_le);
                end else begin
                    e = q_le.pop_front();
                    chk("le_word", {22'd0, dat_le, tgc_le}, {22'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_cyc = 1'b0; s_stb = 1'b0; s_dat = '0; s_tgc = '0; s_cnt = '0;
        d_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs_be", {stall_be, ack_be, cyc_be, stb_be, dat_be, tgc_be}, 0);
        chk("rst_outs_le", {stall_le, ack_le, cyc_le, stb_le, dat_le, tgc_le}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic beat, single ack pulse.
        send(32'h11223344, 2'b11, 3'd4, 4);
        @(posedge clk); #1;
        chk("s_ack_once", ack_be, 0);
        chk("latency_stb", stb_be, 1);
        idle();
        drain("drain_basic");
        chk("cyc_after_basic", cyc_be, 0);

        // Sink back-pressure while 0x22 is presented.
        send(32'h11223344, 2'b11, 3'd4, 4);
        idle();
        @(negedge clk);
        d_ack = 1'b0;
        repeat (3) begin
            #3;
            chk("hold_dat", dat_be, 8'h22);
            chk("hold_stb", stb_be, 1);
            chk("hold_stall", stall_be, 1);
            chk("hold_dat_le", dat_le, 8'h33);
            @(negedge clk);
        end
        d_ack = 1'b1;
        drain("drain_hold");

        // Back-to-back beats at full rate, packet spanning both.
        xfer_log.delete();
        send(32'h01020304, 2'b01, 3'd4, 4);
        send(32'h05060708, 2'b10, 3'd4, 4);
        idle();
        drain("drain_b2b");
        chk("b2b_words", xfer_log.size(), 8);
        if (xfer_log.size() == 8)
            chk("b2b_span", xfer_log[7] - xfer_log[0], 7);
        chk("b2b_cyc_end", cyc_be, 0);

        // Packet open between separate beats keeps d_cyc_o up.
        send(32'hA1A2A3A4, 2'b01, 3'd4, 4);
        idle();
        drain("drain_open");
        chk("open_stb", stb_be, 0);
        chk("open_cyc", cyc_be, 1);
        chk("open_cyc_le", cyc_le, 1);
        send(32'hB1B2B3B4, 2'b10, 3'd4, 4);
        idle();
        drain("drain_close");
        chk("close_cyc", cyc_be, 0);

        // Partial beat.
`ifdef WISH_UNPACKN_CNT_EN
        send(32'hAABBCCDD, 2'b11, 3'd2, 2);
`else
        send(32'hAABBCCDD, 2'b11, 3'd2, 4);
`endif
        idle();
        drain("drain_cnt");
        chk("cnt_empty_stb", stb_be, 0);

        // Reset in the middle of a beat.
        send(32'h11223344, 2'b11, 3'd4, 4);
        idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q_be.delete();
        q_le.delete();
        @(posedge clk); #1;
        chk("mid_rst_stb", stb_be, 0);
        chk("mid_rst_cyc", cyc_be, 0);
        chk("mid_rst_stb_le", stb_le, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h55667788, 2'b11, 3'd4, 4);
        #1;
        chk("post_rst_first", {dat_be, tgc_be}, {8'h55, 2'b01});
        idle();
        drain("drain_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
